mem_arbiter: RTL

Sequences the single unified memory port shared by the fetch stage and the memory stage of the 16-bit pipeline. Accepts word requests from both, grants one at a time under a fixed-then-alternating priority rule, and drives a variable-latency memory with a req/done handshake. Returns read data and per-requester valid pulses, and derives the stall signals that freeze fetch and memory stages. A watchdog flags a hung memory.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/wait_timer.sv | 39 +++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, grant owner
// encoding and the default datapath width.
package mem_arb_pkg;

    parameter int unsigned DefWordW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StBusyIf,
        StBusyDm,
        StDone,
        StErr
    } arb_state_e;

    // Records which requester was served most recently; the other one wins a conflict.
    typedef enum logic {
        GntIf = 1'b0,
        GntDm = 1'b1
    } gnt_e;

endpackage

// File: rtl/wait_timer.sv
// Busy-cycle counter for the memory watchdog. Clear has priority over enable.
// tc flags that the next enabled increment brings the count up to MAX_WAIT.
module wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] Limit = 8'(MAX_WAIT);

    logic [7:0] count_q, count_d;

    // Next count: clear, increment or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Independent of en so the parent can gate it without a combinational loop.
    assign tc = ((count_q + 8'd1) == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between fetch (IF) and data memory (DM).
// One transaction at a time; a conflict goes to the requester not served last.
// Every grant ends with a one-cycle DONE state that carries the valid pulse.
// A hung memory parks the FSM in ERR until reset.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WORD_W   = DefWordW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_data,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [WORD_W-1:0] dm_addr,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic [WORD_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              err
);

    arb_state_e        state_q, state_d;
    gnt_e              last_q, last_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_W-1:0] if_data_q, if_data_d;
    logic [WORD_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic              err_q, err_d;

    logic timer_clr, timer_en, timer_tc;
    logic grant_if, grant_dm;

    wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk(clk),
        .rst(rst),
        .clr(timer_clr),
        .en (timer_en),
        .tc (timer_tc)
    );

    // Conflict resolution: the requester not served last wins.
    always_comb begin
        grant_dm = dm_req && (!if_req || (last_q == GntIf));
        grant_if = if_req && !grant_dm;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        err_d       = err_q;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_dm) begin
                    state_d     = StBusyDm;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = dm_wr;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    timer_clr   = 1'b1;
                end else if (grant_if) begin
                    state_d    = StBusyIf;
                    mem_req_d  = 1'b1;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = if_addr;
                    timer_clr  = 1'b1;
                end
            end

            StBusyIf, StBusyDm: begin
                if (mem_done) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    mem_wr_d  = 1'b0;
                    timer_clr = 1'b1;
                    if (state_q == StBusyIf) begin
                        if_data_d  = mem_rdata;
                        if_valid_d = 1'b1;
                        last_d     = GntIf;
                    end else begin
                        // A write leaves the last read data in place.
                        if (!mem_wr_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                        dm_valid_d = 1'b1;
                        last_d     = GntDm;
                    end
                end else begin
                    timer_en = 1'b1;
                    if (timer_tc) begin
                        state_d   = StErr;
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
                        mem_wr_d  = 1'b0;
                    end
                end
            end

            // Valid pulse is visible this cycle; new requests wait for IDLE.
            StDone: begin
                state_d = StIdle;
            end

            StErr: begin
                state_d = StErr;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= GntIf;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_data   = if_data_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign err       = err_q;

    assign if_stall = if_req & ~if_valid_q;
    assign dm_stall = dm_req & ~dm_valid_q;

endmodule
